// File: rtl/state_seq_pkg.sv
// state_seq_pkg: types and constants shared by the state sequencer and the
// state register bank. VAL_LO/VAL_HI bound the values the bank will accept
// a pulse for; the bank reuses these so both sides agree on the legal window.
package state_seq_pkg;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_PULSE  = 3'd3,
    ST_SETTLE = 3'd4
  } seq_state_t;

  // Operation applied to the addressed register
  typedef enum logic {
    OP_UP   = 1'b0,
    OP_DOWN = 1'b1
  } seq_op_t;

  // Legality bounds: a pulse is only issued when VAL_LO < v < VAL_HI
  localparam int unsigned VAL_LO = 1;
  localparam int unsigned VAL_HI = 5;

  // True when the bank would act on a pulse for value v (unsigned compare)
  function automatic logic val_in_window(input logic [31:0] v);
    return (v > VAL_LO) && (v < VAL_HI);
  endfunction

endpackage

// File: rtl/state_sequencer_if.sv
// state_sequencer_if: address/pulse/read-data bus between the sequencer
// (master) and the state register bank (slave). stateValue is the bank's
// combinational read of the register addressed by state.
interface state_sequencer_if #(
  parameter int BIT_ADDR = 3,
  parameter int BIT_DATO = 3
);

  logic [BIT_ADDR-1:0] state;
  logic                UpState;
  logic                DownState;
  logic [BIT_DATO-1:0] stateValue;

  modport master (
    output state,
    output UpState,
    output DownState,
    input  stateValue
  );

  modport slave (
    input  state,
    input  UpState,
    input  DownState,
    output stateValue
  );

endinterface

// File: rtl/state_sequencer_tick_gen.sv
// tick_gen: free-running divider producing a one-cycle tick every TICK_DIV
// clocks. The counter runs 0..TICK_DIV-1 and the tick is high in the cycle
// whose edge wraps the counter back to 0.
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             wrap;

  assign wrap = (cnt_reg == CNT_LAST);

  // Next counter value: wrap to zero after the last count
  always_comb begin
    cnt_next = cnt_reg + 1'b1;
    if (wrap) begin
      cnt_next = '0;
    end
  end

  // Counter register, cleared by the active-low synchronous reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign tick = wrap;

endmodule

// File: rtl/state_sequencer.sv
// state_sequencer: initiator side of the state register bank.
// Merges a periodic decay scan (decrement addresses 0..NUM_ACTIVE-1) with
// single-register feed requests (increment one address). Each register
// visit is ADDR -> CHECK -> PULSE -> SETTLE, and a pulse is only issued
// when the read value lies strictly inside (VAL_LO, VAL_HI).
// A visit whose pulse is skipped spends the PULSE slot as an extra SETTLE
// cycle, so every visit takes exactly 4 cycles.
// Optional feature: define STATE_SEQ_ALARM_EN to build the sticky low-value
// alarm; otherwise alarm is tied to 0.
module state_sequencer
  import state_seq_pkg::*;
#(
  parameter int BIT_ADDR    = 3,
  parameter int BIT_DATO    = 3,
  parameter int NUM_ACTIVE  = 5,
  parameter int TICK_DIV    = 50_000_000,
  parameter int ALARM_LEVEL = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                feed_req,
  input  logic [BIT_ADDR-1:0] feed_addr,
  state_sequencer_if.master   bus,
  output logic                busy,
  output logic                feed_drop,
  output logic                alarm
);

  localparam logic [BIT_ADDR-1:0] LAST_ADDR = BIT_ADDR'(NUM_ACTIVE - 1);

  // Elaboration-time parameter sanity checks
  if (TICK_DIV < 16) begin : g_bad_tick_div
    $error("state_sequencer: TICK_DIV must be at least 16");
  end
  if (NUM_ACTIVE < 1 || NUM_ACTIVE > (1 << BIT_ADDR)) begin : g_bad_num_active
    $error("state_sequencer: NUM_ACTIVE must fit the address space");
  end
  if (ALARM_LEVEL < 0 || ALARM_LEVEL >= (1 << BIT_DATO)) begin : g_bad_alarm_level
    $error("state_sequencer: ALARM_LEVEL must fit BIT_DATO");
  end

  // Decay timebase
  logic tick;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // FSM and datapath state
  seq_state_t          fsm_reg,       fsm_next;
  seq_op_t             op_reg,        op_next;
  logic [BIT_ADDR-1:0] addr_reg,      addr_next;
  logic                skip_reg,      skip_next;
  logic                feed_pend_reg, feed_pend_next;
  logic [BIT_ADDR-1:0] pend_addr_reg, pend_addr_next;
  logic                tick_pend_reg, tick_pend_next;
  logic                drop_reg,      drop_next;

  logic take_feed;
  logic up_pulse;
  logic down_pulse;

  // Next-state, work selection, pending-slot bookkeeping and pulse decode
  always_comb begin
    fsm_next       = fsm_reg;
    op_next        = op_reg;
    addr_next      = addr_reg;
    skip_next      = skip_reg;
    feed_pend_next = feed_pend_reg;
    pend_addr_next = pend_addr_reg;
    tick_pend_next = tick_pend_reg | tick;
    drop_next      = 1'b0;
    take_feed      = 1'b0;
    up_pulse       = 1'b0;
    down_pulse     = 1'b0;

    case (fsm_reg)
      ST_IDLE: begin
        // A feed (queued, or arriving right now) beats a pending tick
        if (feed_pend_reg || feed_req) begin
          take_feed = 1'b1;
          addr_next = feed_pend_reg ? pend_addr_reg : feed_addr;
          op_next   = OP_UP;
          fsm_next  = ST_ADDR;
        end else if (tick_pend_reg || tick) begin
          addr_next      = '0;
          op_next        = OP_DOWN;
          tick_pend_next = 1'b0;
          fsm_next       = ST_ADDR;
        end
      end

      ST_ADDR: begin
        fsm_next = ST_CHECK;
      end

      ST_CHECK: begin
        if (val_in_window(32'(bus.stateValue))) begin
          fsm_next = ST_PULSE;
        end else begin
          skip_next = 1'b1;
          fsm_next  = ST_SETTLE;
        end
      end

      ST_PULSE: begin
        up_pulse   = (op_reg == OP_UP);
        down_pulse = (op_reg == OP_DOWN);
        fsm_next   = ST_SETTLE;
      end

      ST_SETTLE: begin
        if (skip_reg) begin
          // Hold one more cycle in place of the skipped pulse
          skip_next = 1'b0;
        end else if (op_reg == OP_DOWN && addr_reg < LAST_ADDR) begin
          addr_next = addr_reg + 1'b1;
          fsm_next  = ST_ADDR;
        end else begin
          fsm_next = ST_IDLE;
        end
      end

      default: begin
        fsm_next = ST_IDLE;
      end
    endcase

    // One-deep feed slot. When IDLE consumes the slot, a request in the
    // same cycle refills it; a request seen directly in IDLE with an empty
    // slot bypasses the slot entirely.
    if (take_feed) begin
      if (feed_pend_reg) begin
        feed_pend_next = feed_req;
        pend_addr_next = feed_addr;
      end
    end else if (feed_req) begin
      if (feed_pend_reg) begin
        drop_next = 1'b1;
      end else begin
        feed_pend_next = 1'b1;
        pend_addr_next = feed_addr;
      end
    end
  end

  // State registers with active-low synchronous reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_reg       <= ST_IDLE;
      op_reg        <= OP_UP;
      addr_reg      <= '0;
      skip_reg      <= 1'b0;
      feed_pend_reg <= 1'b0;
      pend_addr_reg <= '0;
      tick_pend_reg <= 1'b0;
      drop_reg      <= 1'b0;
    end else begin
      fsm_reg       <= fsm_next;
      op_reg        <= op_next;
      addr_reg      <= addr_next;
      skip_reg      <= skip_next;
      feed_pend_reg <= feed_pend_next;
      pend_addr_reg <= pend_addr_next;
      tick_pend_reg <= tick_pend_next;
      drop_reg      <= drop_next;
    end
  end

  assign bus.state     = addr_reg;
  assign bus.UpState   = up_pulse;
  assign bus.DownState = down_pulse;
  assign busy          = (fsm_reg != ST_IDLE);
  assign feed_drop     = drop_reg;

`ifdef STATE_SEQ_ALARM_EN
  localparam logic [BIT_DATO-1:0] ALARM_V = BIT_DATO'(ALARM_LEVEL);

  logic alarm_reg, alarm_next;

  // Sticky alarm: set by a low value seen during a scan, cleared by an applied feed
  always_comb begin
    alarm_next = alarm_reg;
    if (fsm_reg == ST_PULSE && op_reg == OP_UP) begin
      alarm_next = 1'b0;
    end else if (fsm_reg == ST_CHECK && op_reg == OP_DOWN &&
                 bus.stateValue <= ALARM_V) begin
      alarm_next = 1'b1;
    end
  end

  // Alarm register
  always_ff @(posedge clk) begin
    if (!rst) begin
      alarm_reg <= 1'b0;
    end else begin
      alarm_reg <= alarm_next;
    end
  end

  assign alarm = alarm_reg;
`else
  assign alarm = 1'b0;
`endif

endmodule

// File: doc/state_sequencer.md
# state_sequencer

Initiator side of the state register bank: it generates the `state` address and the one-cycle `UpState`/`DownState` pulses that the bank consumes, and reads back `stateValue`. It merges two request sources. A periodic decay tick scans addresses 0..NUM_ACTIVE-1 and decrements each one. An external feed request increments one addressed register. It sits between the input drivers/timebase and the register bank. It never issues a pulse the bank would ignore.

## Interface
- `BIT_ADDR`, 3, address width; must match the bank
- `BIT_DATO`, 3, data width; must match the bank
- `NUM_ACTIVE`, 5, number of addresses scanned per decay tick (addresses 0..NUM_ACTIVE-1)
- `TICK_DIV`, 50_000_000, clock cycles per decay tick; minimum 16
- `ALARM_LEVEL`, 2, threshold used by the alarm feature
- `clk` in 1: single clock; all logic on posedge
- `rst` in 1: synchronous reset, active-low (0 = reset)
- `feed_req` in 1: one-cycle request to increment register `feed_addr`
- `feed_addr` in BIT_ADDR: target address, sampled with `feed_req`
- `stateValue` in BIT_DATO: combinational read data from the bank for address `state`
- `state` out BIT_ADDR: address driven to the bank
- `UpState` out 1: increment pulse to the bank
- `DownState` out 1: decrement pulse to the bank
- `busy` out 1: high while the FSM is not in IDLE
- `feed_drop` out 1: one-cycle pulse when a feed request is discarded
- `alarm` out 1: sticky low-value indicator (see Configuration)

## Operation
- FSM states: IDLE, ADDR, CHECK, PULSE, SETTLE.
- **IDLE:** selects work with priority pending feed > pending tick.
  - Feed: latches the target address and sets op=UP.
  - Tick: starts the scan at address 0 and sets op=DOWN.
  - Either case moves to ADDR.
- **ADDR:** drives `state` and lets read data settle. Next state is CHECK.
- **CHECK:** samples `stateValue` into `v`.
  - If 1 < v < 5, go to PULSE.
  - Otherwise skip to SETTLE with no pulse.
- **PULSE:** asserts `UpState` (op=UP) or `DownState` (op=DOWN) for exactly one cycle. Never both.
- **SETTLE:** one cycle for the bank write to land.
  - During a scan, if the address is below NUM_ACTIVE-1, increment it and return to ADDR.
  - Otherwise return to IDLE.
- **Pending feed:** one entry deep.
  - A `feed_req` arriving while the pending slot is full is discarded and pulses `feed_drop`.
  - When the slot is empty, `feed_req` is captured in any state, including the same cycle the slot is consumed.
- **Pending tick:** one flag.
  - A tick arriving while the flag is already set is silently merged.
- **Tick counter:** counts 0..TICK_DIV-1 and wraps. The tick fires on wrap.
- **Address/value handling:** `state` holds its last value outside ADDR..SETTLE. All value comparisons are unsigned BIT_DATO.

## Timing
- **Reset values:** `state`=0, `UpState`=0, `DownState`=0, `busy`=0, `feed_drop`=0, `alarm`=0. Pending feed, pending tick and tick counter are cleared.
- **Reset mid-operation:** aborts at the next edge with no trailing pulse.
- **Feed latency:** `feed_req` in IDLE at cycle N gives ADDR at N+1, CHECK at N+2, and `UpState` high during N+3. `busy` is low again at N+5.
- **Scan latency:** each scanned address takes 4 cycles, so a full scan takes 4·NUM_ACTIVE cycles.
- **Same-cycle tick and feed in IDLE:** the feed runs first and the tick runs immediately after.
- **Feed during a scan:** the feed waits until the whole scan completes. Scans are never interleaved.
- **`feed_addr` out of range:** any value ≥ NUM_ACTIVE is still forwarded unchanged.

## Configuration
- Macro: `STATE_SEQ_ALARM_EN`.
- **Defined:**
  - In CHECK, during a scan, when v ≤ ALARM_LEVEL, `alarm` is set.
  - `alarm` stays set until reset or a successful feed (a PULSE with op=UP).
- **Undefined:** `alarm` is tied to 0 and no compare logic is built.

## Structure
- **Shared package `state_seq_pkg`:**
  - FSM state enum.
  - op enum (UP/DOWN).
  - Bank legality bounds VAL_LO=1 and VAL_HI=5. The bank spec reuses these.
- **Sub-module `tick_gen`:** parameterised by TICK_DIV. It produces a one-cycle `tick` and takes the same `clk`/`rst`.
- Everything else lives in `state_sequencer`.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles, then release → all outputs 0, and the first tick occurs TICK_DIV cycles after release.
- **Single feed:** `feed_req`, `feed_addr`=2, bank value 3 → exactly one `UpState` cycle at N+3 with `state`=2; bank reads 4.
- **Feed gated:** `feed_addr`=0 with value 5 → no `UpState` pulse, and `busy` still lasts 4 cycles.
- **Decay scan:** TICK_DIV=16, bank values {3,1,2,2,5} → `DownState` only on addresses 0, 2, 3; scan takes 20 cycles.
- **Overflow:** three `feed_req` pulses during a scan → the first is queued, the next two each pulse `feed_drop`, and the queued feed executes after the scan.
- **Alarm (with `STATE_SEQ_ALARM_EN`):** value 2 at address 3 during a scan → `alarm`=1. A later feed on any address clears it. Without the macro `alarm` stays 0.
